// File: rtl/arbiter_rr_n_burst.sv
// Round-robin N-input stream arbiter with burst locking and a two-entry
// output skid buffer; ready toward the inputs never depends on out_ready.
module arbiter_rr_n_burst #(
    parameter int N          = 4,
    parameter int DWIDTH     = 16,
    parameter bit BURST_LOCK = 1'b1,
    parameter int IDW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      in_valid,
    input  logic [DWIDTH-1:0] in_data [N],
    input  logic [N-1:0]      in_last,
    output logic [N-1:0]      in_ready,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic [IDW-1:0]    out_id,
    input  logic              out_ready
);

    logic              r_main_valid;
    logic [DWIDTH-1:0] r_main_data;
    logic              r_main_last;
    logic [IDW-1:0]    r_main_id;
    logic              r_skid_valid;
    logic [DWIDTH-1:0] r_skid_data;
    logic              r_skid_last;
    logic [IDW-1:0]    r_skid_id;
    logic              r_lock;
    logic [IDW-1:0]    r_lock_id;
    logic [IDW-1:0]    r_last_grant;

    logic [N-1:0]      w_lock_mask;
    logic [N-1:0]      w_elig;
    logic              w_gnt_vld;
    logic [IDW-1:0]    w_gnt_id;
    int                w_dist;
    int                w_best;
    logic              w_acc;
    logic [DWIDTH-1:0] w_acc_data;
    logic              w_acc_last;

    assign w_lock_mask = N'(1) << r_lock_id;

    // Smallest rotated distance from last_grant+1 wins; a lock narrows
    // eligibility to the locked channel only.
    always_comb begin
        w_elig    = r_lock ? (in_valid & w_lock_mask) : in_valid;
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_best    = N;
        w_dist    = 0;
        for (int j = 0; j < N; j++) begin
            w_dist = j - int'(r_last_grant) - 1;
            if (w_dist < 0) w_dist = w_dist + N;
            if (w_elig[j] && (w_dist < w_best)) begin
                w_best    = w_dist;
                w_gnt_vld = 1'b1;
                w_gnt_id  = IDW'(j);
            end
        end
    end

    assign in_ready = (rst && !r_skid_valid && w_gnt_vld)
                    ? (N'(1) << w_gnt_id) : '0;
    assign w_acc      = |in_ready;
    assign w_acc_last = |(in_last & in_ready);

    always_comb begin
        w_acc_data = '0;
        for (int j = 0; j < N; j++) begin
            if (in_ready[j]) w_acc_data = in_data[j];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_last  <= 1'b0;
            r_main_id    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
            r_skid_id    <= '0;
            r_lock       <= 1'b0;
            r_lock_id    <= '0;
            r_last_grant <= IDW'(N - 1);
        end else begin
            if (w_acc) begin
                r_last_grant <= w_gnt_id;
                r_lock_id    <= w_gnt_id;
                r_lock       <= BURST_LOCK && !w_acc_last;
                if (!r_main_valid || out_ready) begin
                    r_main_valid <= 1'b1;
                    r_main_data  <= w_acc_data;
                    r_main_last  <= w_acc_last;
                    r_main_id    <= w_gnt_id;
                end else begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= w_acc_data;
                    r_skid_last  <= w_acc_last;
                    r_skid_id    <= w_gnt_id;
                end
            end else if (r_main_valid && out_ready) begin
                // Accept is blocked while skid is full, so draining is
                // the only way skid contents move.
                r_main_valid <= r_skid_valid;
                r_skid_valid <= 1'b0;
                if (r_skid_valid) begin
                    r_main_data <= r_skid_data;
                    r_main_last <= r_skid_last;
                    r_main_id   <= r_skid_id;
                end
            end
        end
    end

    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign out_last  = r_main_last;
    assign out_id    = r_main_id;

endmodule

// File: tb/tb_arbiter_rr_n_burst.sv
// Bench for arbiter_rr_n_burst: queue-based reference model for the N=4
// locking build plus directed checks on N=4 unlocked, N=3 and N=1 builds.
module tb_arbiter_rr_n_burst;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  a_valid, a_last, a_ready;
    logic [15:0] a_data [4];
    logic        a_ov, a_ol, a_or;
    logic [15:0] a_od;
    logic [1:0]  a_oid;

    logic [3:0]  b_valid, b_last, b_ready;
    logic [15:0] b_data [4];
    logic        b_ov, b_ol, b_or;
    logic [15:0] b_od;
    logic [1:0]  b_oid;

    logic [2:0]  c_valid, c_last, c_ready;
    logic [15:0] c_data [3];
    logic        c_ov, c_ol, c_or;
    logic [15:0] c_od;
    logic [1:0]  c_oid;

    logic [0:0]  d_valid, d_last, d_ready;
    logic [15:0] d_data [1];
    logic        d_ov, d_ol, d_or;
    logic [15:0] d_od;
    logic [0:0]  d_oid;

    arbiter_rr_n_burst #(.N(4), .DWIDTH(16), .BURST_LOCK(1'b1)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data),
        .in_last(a_last), .in_ready(a_ready), .out_valid(a_ov),
        .out_data(a_od), .out_last(a_ol), .out_id(a_oid),
        .out_ready(a_or));

    arbiter_rr_n_burst #(.N(4), .DWIDTH(16), .BURST_LOCK(1'b0)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data),
        .in_last(b_last), .in_ready(b_ready), .out_valid(b_ov),
        .out_data(b_od), .out_last(b_ol), .out_id(b_oid),
        .out_ready(b_or));

    arbiter_rr_n_burst #(.N(3), .DWIDTH(16), .BURST_LOCK(1'b0)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_data(c_data),
        .in_last(c_last), .in_ready(c_ready), .out_valid(c_ov),
        .out_data(c_od), .out_last(c_ol), .out_id(c_oid),
        .out_ready(c_or));

    arbiter_rr_n_burst #(.N(1), .DWIDTH(16), .BURST_LOCK(1'b1)) u_d (
        .clk(clk), .rst(rst), .in_valid(d_valid), .in_data(d_data),
        .in_last(d_last), .in_ready(d_ready), .out_valid(d_ov),
        .out_data(d_od), .out_last(d_ol), .out_id(d_oid),
        .out_ready(d_or));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: a FIFO of at most two accepted beats plus the
    // round-robin pointer and lock state.
    typedef struct {
        logic [15:0] d;
        logic        l;
        int          id;
    } mbeat_t;

    mbeat_t     mq[$];
    bit         m_lock = 1'b0;
    int         m_lock_id = 0;
    int         m_last = 3;
    logic [3:0] m_acc;
    int         m_g;

    function automatic int m_grant(input logic [3:0] v);
        int g = -1;
        if (m_lock) return v[m_lock_id] ? m_lock_id : -1;
        for (int k = 4; k >= 1; k--)
            if (v[(m_last + k) % 4]) g = (m_last + k) % 4;
        return g;
    endfunction

    function automatic logic [3:0] m_ready();
        int g;
        if (!rst || mq.size() >= 2) return 4'b0;
        g = m_grant(a_valid);
        return (g < 0) ? 4'b0 : (4'b1 << g);
    endfunction

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete();
            m_lock    = 1'b0;
            m_lock_id = 0;
            m_last    = 3;
        end else begin
            m_acc = m_ready();
            m_g   = m_grant(a_valid);
            if (mq.size() > 0 && a_or) void'(mq.pop_front());
            if (m_acc != 4'b0) begin
                mq.push_back('{d: a_data[m_g], l: a_last[m_g], id: m_g});
                m_last    = m_g;
                m_lock_id = m_g;
                m_lock    = !a_last[m_g];
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        chk("in_ready", 32'(a_ready), 32'(m_ready()));
        chk("out_valid", 32'(a_ov), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_data", 32'(a_od), 32'(mq[0].d));
            chk("out_last", 32'(a_ol), 32'(mq[0].l));
            chk("out_id", 32'(a_oid), mq[0].id);
        end
    end

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_t;

    beat_t      srcq[4][$];
    logic [3:0] en = 4'b0;
    bit         or_rand = 1'b0;
    logic       or_val = 1'b1;
    int         log_id[$];
    logic [15:0] log_d[$];

    task automatic cycle();
        logic [3:0] fire;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            a_valid[c] = en[c] && (srcq[c].size() > 0);
            a_data[c]  = 16'h0;
            a_last[c]  = 1'b0;
            if (srcq[c].size() > 0) begin
                a_data[c] = srcq[c][0].d;
                a_last[c] = srcq[c][0].l;
            end
        end
        a_or = or_rand ? 1'($urandom_range(0, 1)) : or_val;
        #4;
        fire = a_valid & a_ready;
        if (a_ov && a_or) begin
            log_id.push_back(int'(a_oid));
            log_d.push_back(a_od);
        end
        @(posedge clk);
        for (int c = 0; c < 4; c++)
            if (fire[c]) void'(srcq[c].pop_front());
        #1;
    endtask

    task automatic run(input int maxc);
        int c = 0;
        while ((srcq[0].size() + srcq[1].size() + srcq[2].size() +
                srcq[3].size() + mq.size()) > 0 && c < maxc) begin
            cycle();
            c++;
        end
        chk("run_bound", 32'(c < maxc), 32'd1);
    endtask

    task automatic chk_log(input string nm, input int ids[],
                           input logic [15:0] ds[]);
        chk({nm, "_len"}, log_id.size(), ids.size());
        for (int i = 0; i < ids.size() && i < log_id.size(); i++) begin
            chk({nm, "_id"}, log_id[i], ids[i]);
            chk({nm, "_data"}, 32'(log_d[i]), 32'(ds[i]));
        end
        log_id.delete();
        log_d.delete();
    endtask

    initial begin
        int          e_id[];
        logic [15:0] e_d[];

        a_valid = 4'hF; a_last = 4'h0; a_or = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data[i] = 16'h0;
            b_data[i] = 16'(16'hB0 + i);
        end
        for (int i = 0; i < 3; i++) c_data[i] = 16'(16'hC0 + i);
        b_valid = 4'hF; b_last = 4'hF; b_or = 1'b1;
        c_valid = 3'h7; c_last = 3'h7; c_or = 1'b1;
        d_valid = 1'b1; d_last = 1'b1; d_or = 1'b1;
        d_data[0] = 16'h100;

        #3;
        chk("rst_out_valid", 32'(a_ov), 32'd0);
        chk("rst_out_data", 32'(a_od), 32'd0);
        chk("rst_out_last", 32'(a_ol), 32'd0);
        chk("rst_out_id", 32'(a_oid), 32'd0);
        chk("rst_in_ready", 32'(a_ready), 32'd0);
        chk("rst_in_ready_b", 32'(b_ready), 32'd0);
        a_valid = 4'h0;

        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("b_first_lat", 32'(b_ov), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            chk("b_valid", 32'(b_ov), 32'd1);
            chk("b_rr_id", 32'(b_oid), k % 4);
            chk("c_rr_id", 32'(c_oid), k % 3);
            chk("c_data", 32'(c_od), 32'(16'hC0 + (k % 3)));
            chk("d_valid", 32'(d_ov), 32'd1);
            chk("d_id", 32'(d_oid), 32'd0);
            chk("d_data", 32'(d_od), 32'(16'h100 + k));
            d_data[0] = 16'(16'h101 + k);
        end
        b_valid = 4'h0;
        c_valid = 3'h0;
        d_valid = 1'b0;

        en = 4'b0100;
        srcq[2].push_back('{16'h21, 1'b0});
        srcq[2].push_back('{16'h22, 1'b0});
        srcq[2].push_back('{16'h23, 1'b1});
        cycle();
        en = 4'b0111;
        srcq[0].push_back('{16'h01, 1'b1});
        srcq[1].push_back('{16'h11, 1'b1});
        run(20);
        e_id = '{2, 2, 2, 0, 1};
        e_d  = '{16'h21, 16'h22, 16'h23, 16'h01, 16'h11};
        chk_log("burst", e_id, e_d);

        en = 4'b0010;
        srcq[1].push_back('{16'h31, 1'b0});
        srcq[1].push_back('{16'h32, 1'b0});
        srcq[1].push_back('{16'h33, 1'b1});
        srcq[3].push_back('{16'h41, 1'b1});
        cycle();
        en = 4'b1000;
        repeat (2) begin
            cycle();
            chk("stall_ready", 32'(a_ready), 32'd0);
        end
        en = 4'b1010;
        run(20);
        e_id = '{1, 1, 1, 3};
        e_d  = '{16'h31, 16'h32, 16'h33, 16'h41};
        chk_log("hold", e_id, e_d);

        en = 4'b0001;
        for (int i = 1; i <= 16; i++) srcq[0].push_back('{16'(i), 1'b1});
        or_rand = 1'b1;
        run(400);
        or_rand = 1'b0;
        chk("bp_count", log_d.size(), 32'd16);
        for (int i = 0; i < 16 && i < log_d.size(); i++)
            chk("bp_order", 32'(log_d[i]), 32'(i + 1));
        log_id.delete();
        log_d.delete();

        or_val = 1'b0;
        en = 4'b1000;
        srcq[3].push_back('{16'h51, 1'b0});
        srcq[3].push_back('{16'h52, 1'b0});
        srcq[3].push_back('{16'h53, 1'b0});
        srcq[3].push_back('{16'h54, 1'b1});
        cycle();
        cycle();
        chk("pre_rst_valid", 32'(a_ov), 32'd1);
        chk("pre_rst_ready", 32'(a_ready), 32'd0);
        en = 4'b1001;
        srcq[0].push_back('{16'h61, 1'b1});
        fork
            begin
                @(negedge clk);
                #2 rst = 1'b0;
                #1 chk("rst_drop_valid", 32'(a_ov), 32'd0);
                #9 rst = 1'b1;
            end
        join_none
        cycle();
        or_val = 1'b1;
        run(20);
        e_id = '{0, 3, 3};
        e_d  = '{16'h61, 16'h53, 16'h54};
        chk_log("post_rst", e_id, e_d);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
